// File: rtl/lsu_pkg.sv
// Shared load/store encodings, the store-buffer entry layout and the store byte-enable helper.
`timescale 1ns/1ps
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WORD_ADDR_W = 30;
  localparam int BE_W        = 4;
  localparam int WORD_W      = 32;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] word_addr;
    logic [BE_W-1:0]        be;
    logic [WORD_W-1:0]      data;
  } sb_entry_t;

  // Zero mask means the store is misaligned or its funct3 is not a store width.
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_B:    be = 4'b0001 << offset;
      F3_H:    be = offset[0] ? 4'b0000 : (4'b0011 << offset);
      F3_W:    be = (offset == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane alignment and load byte/half extraction with sign/zero extension.
`timescale 1ns/1ps
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane_data,
  output logic        st_bad,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [3:0]  ld_lanes,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be  = be_for(st_funct3, st_offset);
    st_bad = (st_be == 4'b0000);
    case (st_funct3)
      F3_B:    st_lane_data = {4{st_data[7:0]}};
      F3_H:    st_lane_data = {2{st_data[15:0]}};
      default: st_lane_data = st_data;
    endcase
  end

  // Halves are taken from the aligned half containing the offset; misalignment is not checked.
  always_comb begin
    ld_byte   = ld_word[8*ld_offset +: 8];
    ld_half   = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    ld_lanes  = 4'b1111;
    ld_result = ld_word;
    case (ld_funct3)
      F3_B: begin
        ld_lanes  = 4'b0001 << ld_offset;
        ld_result = {{24{ld_byte[7]}}, ld_byte};
      end
      F3_BU: begin
        ld_lanes  = 4'b0001 << ld_offset;
        ld_result = {24'h000000, ld_byte};
      end
      F3_H: begin
        ld_lanes  = ld_offset[1] ? 4'b1100 : 4'b0011;
        ld_result = {{16{ld_half[15]}}, ld_half};
      end
      F3_HU: begin
        ld_lanes  = ld_offset[1] ? 4'b1100 : 4'b0011;
        ld_result = {16'h0000, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Store FIFO with one-per-cycle drain, load/drain port arbitration and load extension.
// Define LSU_STB_FWD_EN to forward pending store bytes to loads instead of stalling on overlap.
`timescale 1ns/1ps
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_funct3,
  output logic                  st_err,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             st_err_q, st_err_d;

  logic [3:0]  st_be;
  logic [31:0] st_lane_data;
  logic        st_bad;
  logic [3:0]  ld_lanes;
  logic [31:0] ld_word;
  logic        full, empty, push, drain, ld_grant;
  sb_entry_t   head;

  lsu_align u_align (
    .st_funct3    (st_funct3),
    .st_offset    (st_addr[1:0]),
    .st_data      (st_data),
    .st_be        (st_be),
    .st_lane_data (st_lane_data),
    .st_bad       (st_bad),
    .ld_funct3    (ld_funct3),
    .ld_offset    (ld_addr[1:0]),
    .ld_word      (ld_word),
    .ld_lanes     (ld_lanes),
    .ld_result    (ld_data)
  );

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign st_err   = st_err_q;
  assign sb_empty = empty;
  assign head     = entry_q[rd_ptr_q];
  assign push     = st_valid && !full && !st_bad;

`ifdef LSU_STB_FWD_EN
  logic [31:0]      fwd_word;
  logic [PTR_W-1:0] fwd_idx;

  // Walk from head (oldest) to tail so the newest matching store wins each lane.
  always_comb begin
    fwd_word = mem_rd_data;
    fwd_idx  = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[fwd_idx] && (entry_q[fwd_idx].word_addr == ld_addr[ADDR_WIDTH-1:2]) &&
          ((entry_q[fwd_idx].be & ld_lanes) != 4'b0000)) begin
        for (int b = 0; b < 4; b++) begin
          if (entry_q[fwd_idx].be[b]) fwd_word[8*b +: 8] = entry_q[fwd_idx].data[8*b +: 8];
        end
      end
    end
  end

  assign ld_word  = fwd_word;
  assign ld_stall = ld_valid && full;
`else
  logic ld_hit;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].word_addr == ld_addr[ADDR_WIDTH-1:2]) &&
          ((entry_q[i].be & ld_lanes) != 4'b0000)) ld_hit = 1'b1;
    end
  end

  assign ld_word  = mem_rd_data;
  assign ld_stall = ld_valid && (full || ld_hit);
`endif

  // A full buffer stalls the load, which hands the port to the drain and avoids starvation.
  assign ld_grant  = ld_valid && !ld_stall;
  assign drain     = !reset && !empty && !ld_grant;
  assign mem_wr_en = drain;
  assign mem_be    = drain ? head.be : 4'b0000;
  assign mem_wdata = drain ? head.data : '0;
  assign mem_addr  = drain ? {head.word_addr, 2'b00} : {ld_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    entry_d  = entry_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    st_err_d = st_valid && !full && st_bad;
    if (push) begin
      entry_d[wr_ptr_q] = '{word_addr: st_addr[ADDR_WIDTH-1:2], be: st_be, data: st_lane_data};
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (drain) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(drain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Self-checking bench for lsu_store_buffer: vector tables, directed corner sequences and
// random traffic compared against a queue-based store-buffer model and a reference memory.
`timescale 1ns/1ps
module tb_lsu_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, st_err;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        ld_valid, ld_stall;
  logic [31:0] ld_addr, ld_data;
  logic [2:0]  ld_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rd_data;
  logic        mem_wr_en, sb_empty;
  logic [3:0]  mem_be;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  typedef struct {
    logic [29:0] wa;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;
  ent_t sq[$];
  logic exp_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
  } st_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  st_vec_t st_tab[9];
  ld_vec_t ld_tab[9];

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[7:2]];

  lsu_store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_funct3   (st_funct3),
    .st_err      (st_err),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_funct3   (ld_funct3),
    .ld_data     (ld_data),
    .ld_stall    (ld_stall),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rd_data (mem_rd_data),
    .sb_empty    (sb_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void st_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                   output bit legal, output logic [3:0] be, output logic [31:0] w);
    int size;
    size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    legal = (size != 0) && ((a % size) == 0);
    be    = legal ? 4'(((1 << size) - 1) << (a % 4)) : 4'b0000;
    w     = (size == 1) ? (d & 32'hFF) * 32'h01010101 :
            (size == 2) ? (d & 32'hFFFF) * 32'h00010001 : d;
  endfunction

  function automatic logic [3:0] ld_need(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << (a % 4));
    if (f3 == 3'd1 || f3 == 3'd5) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One clock: inputs are already driven; compare against the model, then advance it.
  task automatic cycle();
    bit          full, hit, legal, exp_stall, grant, drn, wr_s;
    logic [3:0]  be, need, be_s;
    logic [31:0] w, word, wa_s, wd_s;
    #1;
    if (reset) begin
      chk("reset_no_write", mem_wr_en, 0);
      @(posedge clk);
      sq.delete();
      exp_err = 1'b0;
      @(negedge clk);
      return;
    end
    full = (sq.size() == DEPTH);
    chk("st_ready", st_ready, !full);
    chk("st_err", st_err, exp_err);
    chk("sb_empty", sb_empty, sq.size() == 0);
    st_model(st_funct3, st_addr, st_data, legal, be, w);
    need = ld_need(ld_funct3, ld_addr);
    hit = 1'b0;
    foreach (sq[i]) if (sq[i].wa == ld_addr[31:2] && (sq[i].be & need) != 0) hit = 1'b1;
`ifdef LSU_STB_FWD_EN
    exp_stall = ld_valid && full;
`else
    exp_stall = ld_valid && (full || hit);
`endif
    chk("ld_stall", ld_stall, exp_stall);
    grant = ld_valid && !exp_stall;
    drn   = !grant && sq.size() > 0;
    chk("mem_wr_en", mem_wr_en, drn);
    if (drn) begin
      chk("drain_addr", mem_addr, {sq[0].wa, 2'b00});
      chk("drain_be", mem_be, sq[0].be);
      chk("drain_data", mem_wdata, sq[0].d);
    end else begin
      chk("idle_be", mem_be, 0);
    end
    if (grant) begin
      chk("ld_addr", mem_addr, {ld_addr[31:2], 2'b00});
      word = ref_mem[ld_addr[7:2]];
`ifdef LSU_STB_FWD_EN
      foreach (sq[i]) if (sq[i].wa == ld_addr[31:2]) word = merge(word, sq[i].be, sq[i].d);
`endif
      chk("ld_data", ld_data, ld_model(ld_funct3, ld_addr, word));
    end
    wr_s = mem_wr_en; wa_s = mem_addr; be_s = mem_be; wd_s = mem_wdata;
    @(posedge clk);
    if (drn) begin
      ref_mem[sq[0].wa[5:0]] = merge(ref_mem[sq[0].wa[5:0]], sq[0].be, sq[0].d);
      void'(sq.pop_front());
    end
    if (st_valid && !full) begin
      if (legal) sq.push_back('{wa: st_addr[31:2], be: be, d: w});
      exp_err = !legal;
    end else begin
      exp_err = 1'b0;
    end
    if (wr_s === 1'b1) mem[wa_s[7:2]] = merge(mem[wa_s[7:2]], be_s, wd_s);
    @(negedge clk);
  endtask

  task automatic idle();
    st_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    st_tab[0] = '{3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0};
    st_tab[1] = '{3'b000, 32'h21, 32'h000000AB, 4'b0010, 32'hABABABAB, 1'b0};
    st_tab[2] = '{3'b000, 32'h33, 32'h000005C7, 4'b1000, 32'hC7C7C7C7, 1'b0};
    st_tab[3] = '{3'b001, 32'h22, 32'h00001234, 4'b1100, 32'h12341234, 1'b0};
    st_tab[4] = '{3'b001, 32'h30, 32'hFFFF8001, 4'b0011, 32'h80018001, 1'b0};
    st_tab[5] = '{3'b001, 32'h03, 32'h00005555, 4'b0000, 32'h0, 1'b1};
    st_tab[6] = '{3'b010, 32'h12, 32'h12345678, 4'b0000, 32'h0, 1'b1};
    st_tab[7] = '{3'b011, 32'h40, 32'h12345678, 4'b0000, 32'h0, 1'b1};
    st_tab[8] = '{3'b100, 32'h44, 32'h12345678, 4'b0000, 32'h0, 1'b1};

    ld_tab[0] = '{3'b000, 32'h50, 32'hFFFFFF80};
    ld_tab[1] = '{3'b100, 32'h50, 32'h00000080};
    ld_tab[2] = '{3'b000, 32'h51, 32'h0000007F};
    ld_tab[3] = '{3'b000, 32'h52, 32'hFFFFFFFF};
    ld_tab[4] = '{3'b100, 32'h53, 32'h00000080};
    ld_tab[5] = '{3'b001, 32'h50, 32'h00007F80};
    ld_tab[6] = '{3'b001, 32'h52, 32'hFFFF80FF};
    ld_tab[7] = '{3'b101, 32'h52, 32'h000080FF};
    ld_tab[8] = '{3'b010, 32'h50, 32'h80FF7F80};

    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    exp_err = 1'b0;
    reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
    ld_valid = 0; ld_addr = 0; ld_funct3 = 0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_st_err", st_err, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_sb_empty", sb_empty, 1);
    chk("rst_ld_stall", ld_stall, 0);
    cycle();

    // Store alignment table: push one store, check the drain (or error) the next cycle.
    for (int i = 0; i < 9; i++) begin
      do_store(st_tab[i].f3, st_tab[i].addr, st_tab[i].data);
      cycle();
      idle();
      #1;
      chk($sformatf("tab%0d_err", i), st_err, st_tab[i].err);
      chk($sformatf("tab%0d_wr", i), mem_wr_en, !st_tab[i].err);
      chk($sformatf("tab%0d_be", i), mem_be, st_tab[i].be);
      if (!st_tab[i].err) begin
        chk($sformatf("tab%0d_data", i), mem_wdata, st_tab[i].wdata);
        chk($sformatf("tab%0d_addr", i), mem_addr, {st_tab[i].addr[31:2], 2'b00});
      end
      cycle();
      #1;
      chk($sformatf("tab%0d_empty", i), sb_empty, 1);
      cycle();
    end

    // Load extension table over a preloaded word.
    mem[20] = 32'h80FF7F80; ref_mem[20] = 32'h80FF7F80;
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1; ld_funct3 = ld_tab[i].f3; ld_addr = ld_tab[i].addr;
      #1;
      chk($sformatf("ldtab%0d", i), ld_data, ld_tab[i].exp);
      cycle();
    end
    idle();
    cycle();

    // SB then SH into a zeroed word, then LW sees both.
    mem[8] = '0; ref_mem[8] = '0;
    do_store(3'b000, 32'h21, 32'h000000AB);
    cycle();
    do_store(3'b001, 32'h22, 32'h00001234);
    #1;
    chk("sbsh_be0", mem_be, 4'b0010);
    chk("sbsh_data0", mem_wdata, 32'hABABABAB);
    cycle();
    idle();
    #1;
    chk("sbsh_be1", mem_be, 4'b1100);
    cycle();
    ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h20;
    #1;
    chk("sbsh_lw", ld_data, 32'h1234AB00);
    cycle();

    // Fill to DEPTH while a non-overlapping load holds the port.
    ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h80;
    for (int i = 0; i < DEPTH; i++) begin
      do_store(3'b010, 32'(i * 4), 32'hA0000000 + 32'(i));
      cycle();
    end
    do_store(3'b010, 32'h14, 32'hA0000004);
    #1;
    chk("full_st_ready", st_ready, 0);
    chk("full_ld_stall", ld_stall, 1);
    chk("full_drain", mem_wr_en, 1);
    cycle();
    #1;
    chk("after_drain_stall", ld_stall, 0);
    chk("after_drain_ready", st_ready, 1);
    cycle();
    idle();
    for (int i = 0; i < 6; i++) cycle();

    // Store then overlapping byte load on the next cycle.
    do_store(3'b010, 32'h40, 32'h11223344);
    cycle();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_funct3 = 3'b100; ld_addr = 32'h43;
    #1;
`ifdef LSU_STB_FWD_EN
    chk("raw_stall", ld_stall, 0);
    chk("raw_fwd", ld_data, 32'h00000011);
`else
    chk("raw_stall", ld_stall, 1);
    cycle();
    #1;
    chk("raw_stall_after", ld_stall, 0);
    chk("raw_mem", ld_data, 32'h00000011);
`endif
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // Reset with three stores pending: they must never reach memory.
    ld_valid = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      do_store(3'b010, 32'h90 + 32'(4 * i), 32'hBAD00000 + 32'(i));
      cycle();
    end
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_mid_empty", sb_empty, 1);
    chk("rst_mid_wr", mem_wr_en, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("rst_discard", mem[36], 0);

    // Random traffic in a small address window to force overlaps and full conditions.
    for (int n = 0; n < 600; n++) begin
      int r;
      st_valid  = ($urandom_range(0, 3) != 0);
      r         = $urandom_range(0, 11);
      st_funct3 = (r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r < 10) ? 3'd2 : (r == 10) ? 3'd3 : 3'd4;
      st_addr   = $urandom_range(0, 63);
      st_data   = $urandom;
      ld_valid  = ($urandom_range(0, 2) == 0);
      r         = $urandom_range(0, 4);
      ld_funct3 = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 2) ? 3'd2 : (r == 3) ? 3'd4 : 3'd5;
      ld_addr   = $urandom_range(0, 63);
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    for (int i = 0; i < 64; i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
